// File: rtl/muldiv_sequencer.sv
// Iterative MUL/DIV/REM unit for the execute stage: shift-add multiply, restoring divide on
// magnitudes, with divide-by-zero and signed-overflow results resolved without iterating.
//
// state | meaning
// IDLE  | waiting for an accepted op; stall raised combinationally in the accept cycle
// RUN   | one iteration per cycle, XLEN cycles, pipeline held
// DONE  | result valid, done pulse high, pipeline released
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      Function,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            op_mul, op_rem, neg_q, neg_r;
    logic [XLEN-1:0] opa, opb, acc;

    logic            fn_mul, fn_div, fn_rem, fn_valid, special;
    logic [XLEN-1:0] special_val, abs_a, abs_b;
    logic            load_ops, iterate, load_final, load_special;
    logic [XLEN-1:0] acc_nxt, opa_nxt, opb_nxt, final_val;
    logic [XLEN:0]   r_shift, r_sub;
    logic            r_ge;

    assign fn_mul   = (Function == 4'd3);
    assign fn_div   = (Function == 4'd4);
    assign fn_rem   = (Function == 4'd5);
    assign fn_valid = fn_mul | fn_div | fn_rem;

    assign special     = (fn_div | fn_rem) & ((SrcB == '0) | ((SrcA == MIN_NEG) & (SrcB == '1)));
    // Overflow DIV returns MIN_NEG, which is SrcA itself in that case
    assign special_val = (SrcB == '0) ? (fn_div ? '1 : SrcA) : (fn_div ? SrcA : '0);
    assign abs_a       = SrcA[XLEN-1] ? -SrcA : SrcA;
    assign abs_b       = SrcB[XLEN-1] ? -SrcB : SrcB;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        load_ops     = 1'b0;
        iterate      = 1'b0;
        load_final   = 1'b0;
        load_special = 1'b0;
        case (state)
            IDLE: begin
                if (start && fn_valid) begin
                    stall = 1'b1;
                    if (special) begin
                        state_nxt    = DONE;
                        load_special = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        load_ops  = 1'b1;
                    end
                end
            end
            RUN: begin
                stall   = 1'b1;
                iterate = 1'b1;
                if (cnt == LAST) begin
                    state_nxt  = DONE;
                    load_final = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // stall is deliberately left as computed: flush kills the op, not this cycle's hold
        if (flush) begin
            state_nxt    = IDLE;
            load_ops     = 1'b0;
            iterate      = 1'b0;
            load_final   = 1'b0;
            load_special = 1'b0;
        end
    end

    // opa: multiplicand (shifted left) or divisor magnitude
    // opb: multiplier (shifted right) or dividend magnitude shifting into quotient
    // acc: partial product or partial remainder
    always_comb begin
        r_shift   = {acc, opb[XLEN-1]};
        r_sub     = r_shift - {1'b0, opa};
        r_ge      = ~r_sub[XLEN];
        acc_nxt   = acc;
        opa_nxt   = opa;
        opb_nxt   = opb;
        final_val = '0;
        if (op_mul) begin
            acc_nxt = acc + (opb[0] ? opa : '0);
            opa_nxt = opa << 1;
            opb_nxt = opb >> 1;
        end else begin
            acc_nxt = r_ge ? r_sub[XLEN-1:0] : r_shift[XLEN-1:0];
            opb_nxt = {opb[XLEN-2:0], r_ge};
        end
        if (op_mul)      final_val = acc_nxt;
        else if (op_rem) final_val = neg_r ? -acc_nxt : acc_nxt;
        else             final_val = neg_q ? -opb_nxt : opb_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op_mul <= 1'b0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= load_final | load_special;
            if (flush) begin
                cnt <= '0;
            end else if (load_ops) begin
                cnt    <= '0;
                op_mul <= fn_mul;
                op_rem <= fn_rem;
                neg_q  <= SrcA[XLEN-1] ^ SrcB[XLEN-1];
                neg_r  <= SrcA[XLEN-1];
                acc    <= '0;
                opa    <= fn_mul ? SrcA : abs_b;
                opb    <= fn_mul ? SrcB : abs_a;
            end else if (iterate) begin
                cnt <= cnt + 1'b1;
                acc <= acc_nxt;
                opa <= opa_nxt;
                opb <= opb_nxt;
            end
            if (load_final)        result <= final_val;
            else if (load_special) result <= special_val;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results queued at issue, popped on done.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [3:0]  Function;
    logic [31:0] SrcA, SrcB;
    logic        stall, done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res = '0;
    logic [31:0] popped;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Function(Function),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sbv;
        sa  = a;
        sbv = b;
        if (fn == 4'd3) return a * b;
        if (b == 32'h0) return (fn == 4'd4) ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (fn == 4'd4) ? 32'h8000_0000 : 32'h0;
        if (fn == 4'd4) return sa / sbv;
        return sa % sbv;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'h0);
            end else begin
                popped = sb.pop_front();
                check("result", result, popped);
                last_res = popped;
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat, st;
        start    = 1'b1;
        Function = fn;
        SrcA     = a;
        SrcB     = b;
        sb.push_back(exp);
        #1 st = int'(stall);
        @(negedge clk);
        start    = 1'b0;
        Function = 4'd0;
        lat      = 1;
        while (!done && lat < 100) begin
            st += int'(stall);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("stall_cycles", st, exp_lat);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'h0);
    endtask

    initial begin
        logic [3:0]  fn;
        logic [31:0] a, b;
        int          lat;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Function = 4'd0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op(4'd3, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op(4'd4, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 33);
        run_op(4'd5, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 33);
        run_op(4'd4, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 33);
        run_op(4'd5, 32'd20, 32'hFFFF_FFFA, 32'd2, 33);
        run_op(4'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(4'd5, 32'd5, 32'd0, 32'd5, 1);
        run_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        for (int i = 0; i < 12; i++) begin
            fn = 4'(3 + $urandom_range(0, 2));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 4) b = 32'h0;
            if (i == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(fn, a, b, model(fn, a, b),
                   (fn != 4'd3 && (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33);
        end

        // flush at counter 10 of a DIV
        start = 1'b1; Function = 4'd4; SrcA = 32'd100; SrcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1 check("stall_during_flush", {31'b0, stall}, 32'h1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_done", {31'b0, done}, 32'h0);
        check("flush_stall", {31'b0, stall}, 32'h0);
        check("flush_result_kept", result, last_res);
        repeat (3) @(negedge clk);
        check("flush_no_late_done", {31'b0, done}, 32'h0);
        run_op(4'd3, 32'd3, 32'd4, 32'd12, 33);

        // reset mid-RUN
        start = 1'b1; Function = 4'd3; SrcA = 32'h1234; SrcB = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_done", {31'b0, done}, 32'h0);
        check("midrst_result", result, 32'h0);
        check("midrst_stall", {31'b0, stall}, 32'h0);
        last_res = '0;
        reset = 1'b0;
        @(negedge clk);

        // unsupported function codes
        start = 1'b1; Function = 4'd0; SrcA = 32'd9; SrcB = 32'd3;
        #1 check("fn0_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        Function = 4'd2;
        #1 check("fn2_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("badfn_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        check("badfn_done_late", {31'b0, done}, 32'h0);
        check("badfn_result", result, 32'h0);

        // start held high through DONE: second op accepted only in the following IDLE cycle
        start = 1'b1; Function = 4'd3; SrcA = 32'd5; SrcB = 32'd6;
        sb.push_back(32'd30);
        sb.push_back(32'd18);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < 100);
        check("held_lat1", lat, 33);
        SrcA = 32'd2; SrcB = 32'd9;
        #1 check("held_stall_in_done", {31'b0, stall}, 32'h0);
        @(negedge clk);
        #1 check("held_stall_reaccept", {31'b0, stall}, 32'h1);
        check("held_no_double_done", {31'b0, done}, 32'h0);
        lat = 0;
        do begin @(negedge clk); lat++; start = 1'b0; end while (!done && lat < 100);
        check("held_lat2", lat, 33);
        @(negedge clk);
        check("held_done_pulse", {31'b0, done}, 32'h0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multi-cycle execution unit and sequencer for the M-extension ALU function codes: 3 (MUL), 4 (DIV), 5 (REM). It sits beside the single-cycle ALU in the execute stage and takes the decoded 4-bit `Function` code from the control unit. While it runs it holds the pipeline with a stall request, then returns a registered 32-bit result with a one-cycle done pulse. It also resolves the RISC-V divide-by-zero and signed-overflow corner cases without iterating.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  execute-stage instruction valid; sampled only in IDLE.
- `Function`  input  4  decoded ALU code; 3=MUL, 4=DIV, 5=REM; all other codes ignored.
- `SrcA`  input  XLEN  dividend / multiplicand (signed two's complement).
- `SrcB`  input  XLEN  divisor / multiplier (signed two's complement).
- `flush`  input  1  kill the in-flight operation (branch taken / pipeline flush).
- `stall`  output  1  combinational hold request to the pipeline.
- `done`  output  1  registered; high for exactly one cycle when `result` is valid.
- `result`  output  XLEN  registered result; holds its last value until the next completion.

## Operation
- Accepted op: `start && Function∈{3,4,5}` in IDLE. All other `start` values are ignored, with no state change.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on an accepted op. Operands latched, counter=0.
  - IDLE→DONE directly on an accepted DIV/REM with SrcB=0 or (SrcA=0x80000000 and SrcB=0xFFFFFFFF). `result` is loaded at the same edge.
  - RUN: one iteration per cycle. Counter increments each cycle. RUN→DONE on the edge where counter==XLEN-1; `result` is loaded at that edge.
  - DONE→IDLE unconditionally on the next edge. A `start` seen in DONE is not accepted.
- MUL: shift-add over the 32 multiplier bits. `result` = low XLEN bits of SrcA*SrcB, which are identical for signed and unsigned operands.
- DIV/REM: restoring division on operand magnitudes. The quotient is truncated toward zero.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
  - Negation is applied at the final edge.
- Special cases:
  - Divide by zero: DIV → 0xFFFFFFFF; REM → SrcA.
  - Overflow (0x80000000 / -1): DIV → 0x80000000; REM → 0.
- `stall` = (IDLE && accepted op) || RUN. It is low in DONE, so the stalled instruction advances and captures `result` in that cycle.
- `flush` in any state: next state IDLE, counter cleared, `done` stays 0, `result` unchanged. `flush` has priority over `start` and over RUN→DONE at the same edge. `stall` is not masked by `flush` in the current cycle.
- Reset: state IDLE, counter 0, `done`=0, `result`=0, internal operand/accumulator registers 0. Reset applied mid-RUN aborts the op the same way `flush` does.

## Timing
- Normal op: accepted at edge k. RUN occupies edges k+1..k+32. DONE state and `done`=1 follow edge k+32. IDLE follows edge k+33.
  - `stall` is high for 33 cycles: the accept cycle plus 32 RUN cycles.
  - Latency from the accept edge to `done` visible is 32 edges.
- Special-case divide: accepted at edge k; `done`=1 in the cycle after edge k.
  - `stall` is high only during the accept cycle.
  - Latency is 1 edge.
- Back-to-back: the next op is accepted earliest at the IDLE cycle after DONE. Minimum spacing is 34 cycles for normal ops and 2 cycles for special cases.
- `result` changes only on the edge that enters DONE or on reset.

## Test plan
- MUL: SrcA=7, SrcB=0xFFFFFFFD (-3) → `result`=0xFFFFFFEB. `done` is a single pulse 32 edges after accept; `stall` is high exactly 33 cycles.
- DIV/REM signed truncation: -20/6 → 0xFFFFFFFD (-3); -20%6 → 0xFFFFFFFE (-2); 20/-6 → 0xFFFFFFFD; 20%-6 → 2.
- Divide by zero: 5/0 → 0xFFFFFFFF; 5%0 → 5. Overflow: 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. In all four, `done` is high the cycle after accept and `stall` is high for 1 cycle.
- Flush at counter=10 during a DIV → IDLE next edge, no `done`, `result` retains its previous value. A new MUL 3*4 issued immediately after → 12 with normal latency.
- Reset asserted mid-RUN → all outputs 0 next edge. `start` with Function=0 or 2 → `stall`=0 and no `done`.
- `start` held high through DONE → exactly one completion per accept; the second op starts from the following IDLE cycle.
